// File: rtl/calc_engine.sv
// Keypad calculator core: debounced keys, two decimal operands, add/sub/iterative mul, packed-BCD display.
// Latency: key to display DEB+2 cycles; add/sub busy 1+W cycles, mul busy 2W cycles, then done pulse.
// Backpressure: none; key presses arriving while busy are dropped, never queued.
module calc_engine #(
    parameter int DIGITS = 4,
    parameter int DEB    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [11:0]         sw,
    input  logic [1:0]          op_mode,
    output logic [4*DIGITS-1:0] disp,
    output logic                neg,
    output logic                ovf,
    output logic                busy,
    output logic                done,
    output logic [3:0]          led
);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    localparam longint MAXL = pow10(DIGITS) - 1;
    localparam int W  = $clog2(pow10(DIGITS));
    localparam int BW = 4 * DIGITS;
    localparam int PW = 2 * W;
    localparam int CW = $clog2(DEB + 1);
    localparam int IW = $clog2(W + 1);
    localparam int ND = $clog2(DIGITS + 1);
    localparam logic [PW-1:0] MAXV = PW'(MAXL);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [2:0] {S_ENTA, S_ENTB, S_EXEC, S_CONV, S_DONE} state_t;

    function automatic logic [W-1:0] mac10(input logic [W-1:0] x, input logic [3:0] d);
        return (x << 3) + (x << 1) + W'(d);
    endfunction

    function automatic logic [BW-1:0] dd_adj(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++)
            if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
        return r;
    endfunction

    // key path
    logic [11:0]   sync1, sync2, cand, last_stable;
    logic [CW-1:0] stab_cnt;
    logic          stable_hit, onehot, key_evt;
    logic          dig_evt, op_evt, eq_evt;
    logic [3:0]    dig_val;

    // datapath
    state_t         state_q, state_d;
    logic [W-1:0]   a, b, conv_bin;
    logic [ND-1:0]  nd;
    logic [1:0]     op_q;
    logic [PW-1:0]  acc, acc_nxt, mcand;
    logic [IW-1:0]  it;
    logic [BW-1:0]  conv_bcd, bcd_nxt;
    logic [BW+W-1:0] dd_wide;
    logic           res_neg, res_ovf;

    // FSM strobes
    logic app_a, app_b, clr_a, clr_all, to_entb, chain, new_a, start_exec;
    logic exec_last, conv_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1       <= '0;
            sync2       <= '0;
            cand        <= '0;
            stab_cnt    <= '0;
            last_stable <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand     <= sync2;
                stab_cnt <= '0;
            end else if (stab_cnt != CW'(DEB)) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
            if (stable_hit) last_stable <= sync2;
        end
    end

    // The first differing sample arms the counter; DEB further matches make the value stable.
    assign stable_hit = (sync2 == cand) && (stab_cnt == CW'(DEB - 1));
    assign onehot     = (sync2 != '0) && ((sync2 & (sync2 - 12'd1)) == '0);
    assign key_evt    = stable_hit && onehot && (sync2 != last_stable);
    assign dig_evt    = key_evt && (|sync2[11:2]);
    assign op_evt     = key_evt && sync2[1];
    assign eq_evt     = key_evt && sync2[0];

    always_comb begin
        dig_val = '0;
        for (int i = 2; i < 12; i++)
            if (sync2[i]) dig_val = 4'(11 - i);
    end

    always_comb begin
        case (op_q)
            OP_ADD:  acc_nxt = PW'(a) + PW'(b);
            OP_SUB:  acc_nxt = (a >= b) ? PW'(a - b) : PW'(b - a);
            OP_MUL:  acc_nxt = acc + (b[0] ? mcand : '0);
            default: acc_nxt = '0;
        endcase
    end

    assign dd_wide   = {dd_adj(conv_bcd), conv_bin} << 1;
    assign bcd_nxt   = dd_wide[BW+W-1:W];
    assign exec_last = (state_q == S_EXEC) && ((op_q != OP_MUL) || (it == IW'(W - 1)));
    assign conv_last = (state_q == S_CONV) && (it == IW'(W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_ENTA;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        app_a      = 1'b0;
        app_b      = 1'b0;
        clr_a      = 1'b0;
        clr_all    = 1'b0;
        to_entb    = 1'b0;
        chain      = 1'b0;
        new_a      = 1'b0;
        start_exec = 1'b0;
        case (state_q)
            S_ENTA: begin
                if (dig_evt) begin
                    app_a = 1'b1;
                end else if (op_evt) begin
                    if (op_mode == OP_CLR) begin
                        clr_a = 1'b1;
                    end else begin
                        to_entb = 1'b1;
                        state_d = S_ENTB;
                    end
                end
            end
            S_ENTB: begin
                if (dig_evt) begin
                    app_b = 1'b1;
                end else if (eq_evt) begin
                    start_exec = 1'b1;
                    state_d    = S_EXEC;
                end else if (op_evt && op_mode == OP_CLR) begin
                    clr_all = 1'b1;
                    state_d = S_ENTA;
                end
            end
            S_EXEC: if (exec_last) state_d = S_CONV;
            S_CONV: if (conv_last) state_d = S_DONE;
            S_DONE: begin
                if (dig_evt) begin
                    new_a   = 1'b1;
                    state_d = S_ENTA;
                end else if (op_evt) begin
                    if (op_mode == OP_CLR) begin
                        clr_all = 1'b1;
                        state_d = S_ENTA;
                    end else begin
                        to_entb = 1'b1;
                        chain   = 1'b1;
                        state_d = S_ENTB;
                    end
                end
            end
            default: state_d = S_ENTA;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a        <= '0;
            b        <= '0;
            nd       <= '0;
            op_q     <= OP_ADD;
            disp     <= '0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            it       <= '0;
            conv_bin <= '0;
            conv_bcd <= '0;
            res_neg  <= 1'b0;
            res_ovf  <= 1'b0;
        end else begin
            done <= conv_last;
            if ((app_a || app_b) && (nd < ND'(DIGITS))) begin
                if (app_a) a <= mac10(a, dig_val);
                else       b <= mac10(b, dig_val);
                disp <= {disp[BW-5:0], dig_val};
                nd   <= nd + 1'b1;
            end
            if (clr_a || clr_all) begin
                a    <= '0;
                nd   <= '0;
                disp <= '0;
                neg  <= 1'b0;
                ovf  <= 1'b0;
                if (clr_all) b <= '0;
            end
            if (to_entb) begin
                op_q <= op_mode;
                b    <= '0;
                nd   <= '0;
                disp <= '0;
                // A negative or overflowed result cannot seed the next operand.
                if (chain) a <= (neg || ovf) ? '0 : acc[W-1:0];
            end
            if (new_a) begin
                a    <= W'(dig_val);
                nd   <= ND'(1);
                disp <= BW'(dig_val);
                neg  <= 1'b0;
                ovf  <= 1'b0;
            end
            if (start_exec) begin
                acc     <= '0;
                mcand   <= PW'(a);
                it      <= '0;
                res_neg <= (op_q == OP_SUB) && (a < b);
            end
            if (state_q == S_EXEC) begin
                acc <= acc_nxt;
                if (op_q == OP_MUL) begin
                    mcand <= mcand << 1;
                    b     <= b >> 1;
                    it    <= it + 1'b1;
                end
                if (exec_last) begin
                    it       <= '0;
                    res_ovf  <= (acc_nxt > MAXV);
                    conv_bin <= acc_nxt[W-1:0];
                    conv_bcd <= '0;
                end
            end
            if (state_q == S_CONV) begin
                it <= it + 1'b1;
                // Overflowed results still spend W cycles here so busy length is fixed.
                if (!res_ovf) begin
                    conv_bcd <= bcd_nxt;
                    conv_bin <= dd_wide[W-1:0];
                end
                if (conv_last) begin
                    disp <= res_ovf ? '0 : bcd_nxt;
                    neg  <= res_neg;
                    ovf  <= res_ovf;
                end
            end
        end
    end

    assign busy = (state_q == S_EXEC) || (state_q == S_CONV);

    always_comb begin
        case (state_q)
            S_ENTA:  led = 4'b0001;
            S_ENTB:  led = 4'b0010;
            S_DONE:  led = 4'b1000;
            default: led = 4'b0100;
        endcase
    end

endmodule

// File: tb/tb_calc_engine.sv
// Scoreboarded bench for calc_engine: key presses drive a decimal reference model,
// results are queued at equals and checked by a monitor on every done pulse.
module tb_calc_engine;
    localparam int DIGITS = 4;
    localparam int DEB    = 4;
    localparam int W      = 14;
    localparam int MAXV   = 9999;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sw;
    logic [1:0]  op_mode;
    logic [15:0] disp;
    logic        neg, ovf, busy, done;
    logic [3:0]  led;

    always #5 clk = ~clk;

    calc_engine #(.DIGITS(DIGITS), .DEB(DEB)) dut (
        .clk(clk), .rst(rst), .sw(sw), .op_mode(op_mode),
        .disp(disp), .neg(neg), .ovf(ovf), .busy(busy), .done(done), .led(led)
    );

    typedef struct {
        logic [15:0] disp;
        logic        neg;
        logic        ovf;
        int          blen;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // reference model state: 0 entering a, 1 entering b, 2 showing result
    int m_mode, m_a, m_b, m_nd, m_op, m_res, m_neg, m_ovf, m_disp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_led();
        if (m_mode == 0) return 4'b0001;
        if (m_mode == 1) return 4'b0010;
        return 4'b1000;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_a = 0; m_b = 0; m_nd = 0; m_op = 0;
        m_res = 0; m_neg = 0; m_ovf = 0; m_disp = 0;
    endtask

    task automatic model_digit(input int d);
        if (m_mode == 2) begin
            m_a = d; m_nd = 1; m_neg = 0; m_ovf = 0; m_mode = 0; m_disp = d;
        end else if (m_nd < DIGITS) begin
            if (m_mode == 0) begin m_a = m_a * 10 + d; m_disp = m_a; end
            else             begin m_b = m_b * 10 + d; m_disp = m_b; end
            m_nd++;
        end
    endtask

    task automatic model_op(input int o);
        if (o == 3) begin
            if (m_mode == 0) begin
                m_a = 0; m_nd = 0; m_neg = 0; m_ovf = 0; m_disp = 0;
            end else begin
                model_reset();
            end
        end else if (m_mode != 1) begin
            if (m_mode == 2) m_a = (m_neg == 0 && m_ovf == 0) ? m_res : 0;
            m_op = o; m_b = 0; m_nd = 0; m_mode = 1; m_disp = 0;
        end
    endtask

    task automatic press_raw(input int idx, input int hold, input int gap);
        @(negedge clk);
        sw = '0;
        sw[idx] = 1'b1;
        repeat (hold) @(negedge clk);
        sw = '0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic key_digit(input int d);
        press_raw(11 - d, 10, 10);
        model_digit(d);
        check("digit_disp", 32'(disp), 32'(to_bcd(m_disp)));
        check("digit_led", 32'(led), 32'(exp_led()));
    endtask

    task automatic key_op(input int o);
        op_mode = 2'(o);
        press_raw(1, 10, 10);
        model_op(o);
        check("op_disp", 32'(disp), 32'(to_bcd(m_disp)));
        check("op_led", 32'(led), 32'(exp_led()));
    endtask

    // drop_try: while a multiply is busy, press a digit that must be discarded
    task automatic key_eq(input bit drop_try);
        exp_t e;
        int   r;
        bit   n, o, dropx;
        dropx = drop_try && m_mode == 1 && m_op == 2;
        if (m_mode == 1) begin
            n = 0;
            if (m_op == 0)      r = m_a + m_b;
            else if (m_op == 1) begin n = (m_a < m_b); r = n ? m_b - m_a : m_a - m_b; end
            else                r = m_a * m_b;
            o = (r > MAXV);
            e.disp = o ? 16'h0 : to_bcd(r);
            e.neg  = n;
            e.ovf  = o;
            e.blen = (m_op == 2) ? 2 * W : 1 + W;
            q.push_back(e);
            m_res = r; m_neg = int'(n); m_ovf = int'(o);
            m_mode = 2; m_disp = o ? 0 : r;
        end
        press_raw(0, 10, 10);
        if (dropx) press_raw(11 - int'($urandom_range(0, 9)), 10, 10);
        wait_idle();
        check("eq_disp", 32'(disp), 32'(to_bcd(m_disp)));
        check("eq_led", 32'(led), 32'(exp_led()));
    endtask

    // monitor: pops one expectation per done pulse and measures busy length
    int busy_cnt = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            busy_cnt = 0;
        end else begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                exp_t e;
                check("done_pulse_width", 32'(prev_done), 32'd0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done pulse, expected none");
                end else begin
                    e = q.pop_front();
                    check("res_disp", 32'(disp), 32'(e.disp));
                    check("res_neg", 32'(neg), 32'(e.neg));
                    check("res_ovf", 32'(ovf), 32'(e.ovf));
                    check("busy_len", 32'(busy_cnt), 32'(e.blen));
                    check("done_led", 32'(led), 32'd8);
                end
                busy_cnt = 0;
            end
        end
        prev_done = done;
    end

    initial begin
        int lat, r, o;
        rst = 1'b0;
        sw = '0;
        op_mode = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_disp", 32'(disp), 32'd0);
        check("rst_neg", 32'(neg), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_led", 32'(led), 32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 12 + 34
        key_digit(1); key_digit(2); key_op(0); key_digit(3); key_digit(4); key_eq(0);
        check("tp1_disp", 32'(disp), 32'h0046);
        // 99 * 99
        key_digit(9); key_digit(9); key_op(2); key_digit(9); key_digit(9); key_eq(0);
        check("tp2_disp", 32'(disp), 32'h9801);
        // overflow, then chain from zero
        for (int i = 0; i < 5; i++) key_digit(9);
        check("tp3_fifth_ignored", 32'(disp), 32'h9999);
        key_op(2); key_digit(2); key_eq(0);
        check("tp3_ovf", 32'(ovf), 32'd1);
        key_op(0); key_digit(5); key_eq(0);
        check("tp3_chain", 32'(disp), 32'h0005);
        // 5 - 8, then new entry
        key_digit(5); key_op(1); key_digit(8); key_eq(0);
        check("tp4_neg", 32'(neg), 32'd1);
        key_digit(7);
        check("tp4_neg_clr", 32'(neg), 32'd0);
        check("tp4_disp", 32'(disp), 32'h0007);

        // key latency from first sampling edge
        key_op(3);
        @(negedge clk);
        sw = '0;
        sw[11-5] = 1'b1;
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (lat < 0 && disp !== 16'h0) lat = k;
        end
        sw = '0;
        repeat (10) @(negedge clk);
        model_digit(5);
        check("key_latency", 32'(lat), 32'(DEB + 2));

        // glitches, multi-hot and repeat detection
        key_op(3);
        press_raw(11 - 3, DEB, 15);
        check("glitch_ignored", 32'(disp), 32'h0);
        @(negedge clk);
        sw = '0; sw[11-1] = 1'b1; sw[11-2] = 1'b1;
        repeat (10) @(negedge clk);
        sw = '0;
        repeat (15) @(negedge clk);
        check("multihot_ignored", 32'(disp), 32'h0);
        press_raw(11 - 3, 10, 2);
        press_raw(11 - 3, 10, 10);
        model_digit(3);
        check("no_gap_one_event", 32'(disp), 32'h0003);
        key_digit(3);
        check("gap_two_events", 32'(disp), 32'h0033);

        // randomised key sequences
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                key_digit($urandom_range(0, 9));
            end else if (r < 8) begin
                o = $urandom_range(0, 7);
                key_op(o >= 6 ? 3 : o % 3);
            end else begin
                key_eq($urandom_range(0, 1) == 1);
            end
        end

        // reset in the middle of busy
        key_op(3); key_digit(1); key_op(0); key_digit(2);
        @(negedge clk);
        sw = 12'b1;
        r = 0;
        while (busy !== 1'b1 && r < 40) begin
            @(negedge clk);
            r++;
        end
        check("abort_busy_seen", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        sw = '0;
        #1;
        check("abort_disp", 32'(disp), 32'd0);
        check("abort_neg", 32'(neg), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_led", 32'(led), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        key_digit(6); key_op(0); key_digit(1); key_eq(0);
        check("tp6_disp", 32'(disp), 32'h0007);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
